// File: rtl/enemy_fire_scheduler.sv
// Picks a pseudo-random live enemy after each cooldown and issues a one-cycle
// launch strobe to the lowest free missile slot.
module enemy_fire_scheduler #(
  parameter int         NUM_SLOTS       = 4,
  parameter int         COOLDOWN_FRAMES = 20,
  parameter logic [4:0] LFSR_SEED       = 5'd1
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  frame_tick,
  input  logic                  game_active,
  input  logic [23:0]           present,
  input  logic [23:0][9:0]      enemy_posX,
  input  logic [23:0][9:0]      enemy_posY,
  input  logic [NUM_SLOTS-1:0]  slot_busy,
  output logic [NUM_SLOTS-1:0]  fire_req,
  output logic [9:0]            fire_X,
  output logic [9:0]            fire_Y,
  output logic [4:0]            shooter_idx,
  output logic [7:0]            shots_fired
);

  localparam int CW = (COOLDOWN_FRAMES > 1) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
  localparam logic [CW-1:0] COOL_RELOAD = CW'(COOLDOWN_FRAMES);
  localparam logic [4:0]    LAST_ENEMY  = 5'd23;

  typedef enum logic [1:0] {IDLE, COOL, SCAN, ISSUE} state_t;

  state_t         state;
  logic [4:0]     lfsr;
  logic [CW-1:0]  cool_cnt;
  logic [4:0]     scan_idx;
  logic [4:0]     scan_cnt;
  logic [4:0]     lat_idx;
  logic [9:0]     lat_x;
  logic [9:0]     lat_y;

  logic [4:0]           candidate;
  logic [NUM_SLOTS-1:0] free_onehot;
  logic                 any_free;

  function automatic logic [4:0] wrap_inc(input logic [4:0] i);
    return (i == LAST_ENEMY) ? 5'd0 : i + 5'd1;
  endfunction

  // Folding 24..31 back onto 0..7 keeps every start index in range.
  assign candidate = (lfsr < 5'd24) ? lfsr : lfsr - 5'd24;
  assign any_free  = |(~slot_busy);

  // NOTE: every variable gets a default before the loop, so no latch is inferred.
  always_comb begin
    free_onehot = '0;
    for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
      if (!slot_busy[k]) free_onehot = NUM_SLOTS'(1) << k;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // right-hand side sees the pre-edge value regardless of statement order.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      lfsr        <= LFSR_SEED;
      cool_cnt    <= COOL_RELOAD;
      scan_idx    <= '0;
      scan_cnt    <= '0;
      lat_idx     <= '0;
      lat_x       <= '0;
      lat_y       <= '0;
      fire_req    <= '0;
      fire_X      <= '0;
      fire_Y      <= '0;
      shooter_idx <= '0;
      shots_fired <= '0;
    end else begin
      lfsr     <= {lfsr[3:0], lfsr[4] ^ lfsr[3]};
      fire_req <= '0;
      if (!game_active) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            state    <= COOL;
            cool_cnt <= COOL_RELOAD;
          end
          COOL: begin
            if (cool_cnt == '0) begin
              state    <= SCAN;
              scan_idx <= candidate;
              scan_cnt <= '0;
            end else if (frame_tick) begin
              cool_cnt <= cool_cnt - 1'b1;
            end
          end
          SCAN: begin
            if (present[scan_idx]) begin
              lat_idx <= scan_idx;
              lat_x   <= enemy_posX[scan_idx];
              lat_y   <= enemy_posY[scan_idx];
              state   <= ISSUE;
            end else if (scan_cnt == LAST_ENEMY) begin
              state    <= COOL;
              cool_cnt <= COOL_RELOAD;
            end else begin
              scan_idx <= wrap_inc(scan_idx);
              scan_cnt <= scan_cnt + 5'd1;
            end
          end
          ISSUE: begin
            if (any_free) begin
              fire_req    <= free_onehot;
              fire_X      <= lat_x;
              fire_Y      <= lat_y;
              shooter_idx <= lat_idx;
              if (shots_fired != 8'hFF) shots_fired <= shots_fired + 8'd1;
              cool_cnt    <= COOL_RELOAD;
              state       <= COOL;
            end else if (!present[lat_idx]) begin
              // Shooter died while waiting for a slot: resume the search after it.
              state    <= SCAN;
              scan_idx <= wrap_inc(lat_idx);
              scan_cnt <= '0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/enemy_fire_scheduler.md
ENEMY_FIRE_SCHEDULER -- requirements
Module: enemy_fire_scheduler

Interface
REQ-001 SHALL have parameter NUM_SLOTS, default 4, number of enemy missile slots arbitrated.
REQ-002 SHALL have parameter COOLDOWN_FRAMES, default 20, frame ticks between consecutive shots.
REQ-003 SHALL have parameter LFSR_SEED, default 5'd1, LFSR reset value; nonzero.
REQ-004 Clk  input  1  system clock; all state on posedge Clk (single clock).
REQ-005 Reset  input  1  asynchronous, active-high reset.
REQ-006 frame_tick  input  1  one-Clk pulse per video frame.
REQ-007 game_active  input  1  firing allowed while high.
REQ-008 present  input  24  bit i high = enemy i alive.
REQ-009 enemy_posX  input  24x10  enemy X positions, index 0..23.
REQ-010 enemy_posY  input  24x10  enemy Y positions, index 0..23.
REQ-011 slot_busy  input  NUM_SLOTS  bit k high = missile slot k in flight.
REQ-012 fire_req  output  NUM_SLOTS  one-hot, one-cycle launch strobe to slot k.
REQ-013 fire_X, fire_Y  output  10 each  launch coordinates, valid with fire_req.
REQ-014 shooter_idx  output  5  index of enemy that fired.
REQ-015 shots_fired  output  8  saturating count of issued shots.

Function
REQ-016 LFSR SHALL advance every Clk: next = {lfsr[3:0], lfsr[4]^lfsr[3]}; never zero.
REQ-017 Candidate SHALL be lfsr when lfsr<24, else lfsr-24.
REQ-018 FSM states IDLE, COOL, SCAN, ISSUE; all outputs registered.
REQ-019 IDLE: when game_active=1, next state COOL with cool_cnt=COOLDOWN_FRAMES.
REQ-020 COOL: cool_cnt decrements by 1 on each frame_tick while nonzero; when cool_cnt==0, next cycle enters SCAN with scan_idx=candidate, scan_cnt=0.
REQ-021 SCAN: examines one enemy per cycle; if present[scan_idx], latch idx, posX, posY and go ISSUE; else scan_idx wraps 23->0, scan_cnt++.
REQ-022 SCAN: after 24 consecutive misses (scan_cnt reaches 23 with miss), SHALL go COOL with cool_cnt reloaded; no fire_req.
REQ-023 ISSUE: if any slot_busy bit low, assert fire_req for the lowest-index free slot for exactly one cycle, with fire_X/fire_Y/shooter_idx = latched values in that cycle; reload cool_cnt, go COOL.
REQ-024 ISSUE with all slots busy: SHALL wait, holding latched values, fire_req=0.
REQ-025 ISSUE waiting and present[latched idx] drops: return to SCAN starting at latched idx+1 (wrapping), scan_cnt=0.
REQ-026 game_active low in any state: next state IDLE; fire_req=0 from that edge; in-progress shot discarded.
REQ-027 fire_X, fire_Y, shooter_idx SHALL hold last issued values between strobes.
REQ-028 shots_fired SHALL increment on each fire_req strobe, saturating at 255.
REQ-029 At most one fire_req bit high in any cycle; never two consecutive strobe cycles.
REQ-030 Max latency COOL-expiry to fire_req with a free slot and >=1 enemy alive: 25 Clk cycles.

Reset
REQ-031 Reset high SHALL immediately force: state IDLE, lfsr=LFSR_SEED, cool_cnt=COOLDOWN_FRAMES, fire_req=0, fire_X=0, fire_Y=0, shooter_idx=0, shots_fired=0.
REQ-032 Reset asserted mid-ISSUE SHALL suppress any pending strobe; after release no fire_req before a full cooldown.

Verification
REQ-033 COOLDOWN_FRAMES=2, all present, slot_busy=0, game_active=1 -> exactly one fire_req=4'b0001 after 2nd frame_tick, within 25 Clk; fire_X/Y equal posX/posY[shooter_idx].
REQ-034 Only present[5]=1, posX[5]=100, posY[5]=40 -> every shot has shooter_idx=5, fire_X=100, fire_Y=40, regardless of candidate.
REQ-035 present=0 -> no fire_req over 10 cooldown periods; FSM cycles SCAN->COOL.
REQ-036 slot_busy=4'b1111 held 50 cycles then 4'b1011 -> no strobe while full; then single fire_req=4'b0100.
REQ-037 Waiting in ISSUE, clear present[latched idx] with one other enemy alive -> strobe uses the other enemy's index and coordinates.
REQ-038 game_active dropped during SCAN, or Reset pulsed during ISSUE -> no strobe; outputs at reset/held values; shots_fired unchanged (Reset: 0).
